// File: rtl/regbank_pkg.sv
// Shared register-bank widths and grant encodings for the writeback arbiter.
package regbank_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int CNT_WIDTH      = 16;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: on contention the side not granted last wins.
module rr_arbiter2
  import regbank_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     lastGrant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (lastGrant == GRANT_B) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto one register-bank write port,
// with a single registered output stage and a saturating contention counter.
module reg_write_arbiter
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  aValid,
  input  logic [ADDR_WIDTH-1:0] aRd,
  input  logic [DATA_WIDTH-1:0] aData,
  output logic                  aReady,
  input  logic                  bValid,
  input  logic [ADDR_WIDTH-1:0] bRd,
  input  logic [DATA_WIDTH-1:0] bData,
  output logic                  bReady,
  output logic                  regWrite,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic [CNT_WIDTH-1:0]  conflictCount
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic                  aZero, bZero;
  logic [1:0]            req_p0, grant_p0;
  logic                  contend_p0;
  grant_e                lastGrant;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] rd_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [CNT_WIDTH-1:0]  cnt_p1;

  // Stage 0: request decode and combinational grant
  assign aZero      = (aRd == '0);
  assign bZero      = (bRd == '0);
  assign req_p0     = {bValid & ~bZero & ~reset, aValid & ~aZero & ~reset};
  assign contend_p0 = &req_p0;

  rr_arbiter2 u_rr (
    .req       (req_p0),
    .lastGrant (lastGrant),
    .grant     (grant_p0)
  );

  // x0 writes are absorbed immediately without taking a grant
  assign aReady = aValid & ~reset & (aZero | grant_p0[0]);
  assign bReady = bValid & ~reset & (bZero | grant_p0[1]);

  // Stage 1: registered write port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      rd_p1     <= '0;
      data_p1   <= '0;
      cnt_p1    <= '0;
      lastGrant <= GRANT_B;
    end else begin
      vld_p1 <= |grant_p0;
      if (grant_p0[0]) begin
        rd_p1     <= aRd;
        data_p1   <= aData;
        lastGrant <= GRANT_A;
      end else if (grant_p0[1]) begin
        rd_p1     <= bRd;
        data_p1   <= bData;
        lastGrant <= GRANT_B;
      end
      if (contend_p0) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign regWrite      = vld_p1;
  assign rd            = rd_p1;
  assign writeData     = data_p1;
  assign conflictCount = cnt_p1;

endmodule
